// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter and
// selectable edge mode, producing one-cycle pulses and sticky pending flags.
module multi_edge_detect #(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER      = 0,
    parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [WIDTH-1:0]     din,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     pulse,
    output logic [WIDTH-1:0]     pending,
    output logic                 irq
);

    localparam int               CNT_W   = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [WIDTH-1:0] pending_q, pending_d;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] rise, fall;
    logic [WIDTH-1:0] mode_rise, mode_fall;

    // Only the last synchroniser stage is ever observed by downstream logic.
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = din;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // A disagreement must persist for FILTER+1 samples; any agreement restarts it.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mode_rise = '0;
        mode_fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mode_rise[i] = mode[2*i];
            mode_fall[i] = mode[2*i+1];
        end
    end

    assign rise      = level_d & ~level_q;
    assign fall      = ~level_d & level_q;
    assign pulse_d   = (rise & mode_rise) | (fall & mode_fall);
    assign pending_d = pulse_d | (pending_q & ~clr);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q   <= INIT;
            pulse_q   <= '0;
            pending_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
        end
    end

    assign level   = level_q;
    assign pulse   = pulse_q;
    assign pending = pending_q;
    assign irq     = |pending_q;

endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Parametrised multi-channel edge detector for asynchronous or slower-domain control inputs such as PHI0/PHI2, RDY, IRQ and NMI lines. Each channel has a synchroniser, a glitch filter and a per-channel edge mode (rising, falling, both or off). On each detected edge a channel produces a one-cycle pulse and sets a sticky pending flag, which software or a downstream FSM clears. This block supersedes single-bit edge detection in the CPU-interface clock domain wherever several lines need consistent, filtered edge events.

## Interface
- WIDTH, 4: number of independent channels.
- SYNC_STAGES, 2: synchroniser depth. Minimum 1.
- FILTER, 0: glitch filter length in clk cycles. 0 means no filtering.
- INIT, {WIDTH{1'b0}}: reset level of each channel's synchroniser and filtered level.
- clk  input  1  sampling clock; all state updates on its rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- din  input  WIDTH  raw channel inputs, asynchronous to clk.
- mode  input  2*WIDTH  per-channel mode, with bits [2i+1:2i] for channel i: 00 off, 01 rising, 10 falling, 11 both.
- clr  input  WIDTH  write-one-to-clear for the pending flags; level-sensitive each cycle.
- level  output  WIDTH  filtered, synchronised level per channel.
- pulse  output  WIDTH  one-cycle edge strobe per channel.
- pending  output  WIDTH  sticky edge flags.
- irq  output  1  OR of all pending bits.

## Operation
- Synchroniser: each channel has a SYNC_STAGES-deep flop chain clocked on posedge clk; s[i] is the last stage.
- Filter, per channel:
  - Counter width is clog2(FILTER+1), minimum 1 bit.
  - If s != level: when cnt == FILTER, level <= s and cnt <= 0; otherwise cnt <= cnt+1.
  - If s == level: cnt <= 0. Any agreement restarts the count, so glitches are rejected.
  - FILTER=0: level follows s with one register of delay.
- Edge qualification:
  - rise_i = level update 0->1 this cycle; fall_i = level update 1->0 this cycle.
  - pulse[i] <= (rise_i & mode[2i]) | (fall_i & mode[2i+1]). pulse is registered and asserts in the same cycle that level changes.
- Pending:
  - pending[i] <= pulse_cond | (pending[i] & ~clr[i]).
  - Set and clear in the same cycle: set wins, and the flag stays 1.
- irq is combinational: irq = |pending.
- Mode 00 masks pulse and pending only. The filter and level keep tracking, so enabling a channel never produces a false edge.
- A mode change takes effect on the next qualification. An edge coinciding with the mode write is judged by the new mode value sampled on that clk.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulse.

## Timing
- Reset (rst_b low, asynchronous):
  - Sync chains and level go to INIT.
  - Counters, pulse and pending go to 0, so irq is 0.
  - No edge is reported on the first cycles after reset if din equals INIT.
- Latency: a din change first captured at clk edge E0 gives level and pulse updated at edge E0 + SYNC_STAGES + FILTER. Example: SYNC_STAGES=2, FILTER=0 gives 2 edges.
- Pulse width: exactly one clk cycle per edge. A second edge needs at least FILTER+1 stable cycles at s.
- Minimum detectable din pulse: a high or low time of at least FILTER+1 clk periods, plus synchroniser uncertainty of one cycle. Shorter pulses are dropped with no pulse and no pending.
- Wrap-around: the counter saturates by construction at FILTER and never exceeds it.
- Reset asserted mid-filter or mid-pulse clears state immediately. The first edge after release is judged against INIT.
- Metastability is contained to stage 1 only. No logic reads any stage other than s.

## Test plan
- Reset: WIDTH=4, INIT=4'b0101, din=4'b0101, mode all 11, release rst_b → pulse, pending and irq stay 0 for 20 cycles; level=4'b0101.
- Latency, rising mode: SYNC_STAGES=2, FILTER=3, channel 0 mode 01, din[0] 0->1 held → pulse[0] high exactly one cycle at capture edge +5. pending[0]=1, irq=1, level[0]=1. A later 1->0 gives no pulse, and level[0]=0 after 5 edges.
- Glitch rejection: FILTER=3, din[1] high for 3 clk cycles then low → no change on level[1], no pulse, no pending. High for 6 cycles → exactly one pulse.
- Both-edges mode: mode=11 on channel 2, din[2] toggled every 10 cycles four times → four single-cycle pulses; pending[2] set after the first pulse.
- Clear vs set collision: pending[3]=1, assert clr[3] in the same cycle as a new pulse[3] → pending[3] stays 1. clr[3] alone on the next cycle → pending[3]=0, irq=0.
- Masking and async reset: mode=00 on channel 0 across edges → no pulse or pending while level tracks. Switching to 01 after a stable high → no pulse. Asserting rst_b low mid-count → all outputs go to their reset values immediately, without waiting for a clk edge.
